// File: rtl/vc_output_arbiter.sv
// Per-input-port VC scheduler: round-robin grant among credited VCs, one registered flit out.
// Optional packet lock (ARB/HOLD) is compiled in when VC_ARB_PKT_LOCK_EN is defined.
module vc_output_arbiter #(
   parameter int VC_NUM       = 4,
   parameter int VC_ID_W      = 2,
   parameter int CREDIT_DEPTH = 4,
   parameter int CNT_W        = 3,
   parameter int FLIT_SIZE    = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [FLIT_SIZE*VC_NUM-1:0] flit_in,
   input  logic [0:VC_NUM-1]           vc_valid,
   input  logic [0:VC_NUM-1]           vc_tail,
   input  logic [0:VC_NUM-1]           credit_return,
   input  logic                        out_ready,
   output logic [0:VC_NUM-1]           vc_pop,
   output logic [FLIT_SIZE-1:0]        flit_out,
   output logic                        flit_valid,
   output logic [VC_ID_W-1:0]          grant_vc
);

   logic [CNT_W-1:0]     cnt [VC_NUM];
   logic [VC_ID_W-1:0]   ptr;
   logic [0:VC_NUM-1]    req;
   logic [0:VC_NUM-1]    lock_mask;
   logic                 any_req;
   logic                 grant;
   logic [VC_ID_W-1:0]   gnt_id;
   logic [VC_ID_W-1:0]   idx;
   logic                 ptr_adv;
   logic [FLIT_SIZE-1:0] gnt_flit;

   function automatic logic [VC_ID_W-1:0] wrap_add(input logic [VC_ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= VC_NUM) s = s - VC_NUM;
      return VC_ID_W'(s);
   endfunction

   // Saturating credit update; a grant and a return in the same cycle cancel.
   function automatic logic [CNT_W-1:0] credit_next(input logic [CNT_W-1:0] c,
                                                    input logic dec, input logic inc);
      if (dec && !inc) return c - 1'b1;
      if (inc && !dec && (c != CNT_W'(CREDIT_DEPTH))) return c + 1'b1;
      return c;
   endfunction

`ifdef VC_ARB_PKT_LOCK_EN
   typedef enum logic {ARB = 1'b0, HOLD = 1'b1} state_t;
   state_t             state, state_nxt;
   logic [VC_ID_W-1:0] lock_vc, lock_vc_nxt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ARB;
         lock_vc <= '0;
      end else begin
         state   <= state_nxt;
         lock_vc <= lock_vc_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      lock_vc_nxt = lock_vc;
      if (grant) begin
         if ((state == ARB) && !vc_tail[gnt_id]) begin
            state_nxt   = HOLD;
            lock_vc_nxt = gnt_id;
         end else if ((state == HOLD) && vc_tail[gnt_id]) begin
            state_nxt = ARB;
         end
      end
   end

   always_comb begin
      lock_mask = '1;
      if (state == HOLD) begin
         for (int i = 0; i < VC_NUM; i++) lock_mask[i] = (lock_vc == VC_ID_W'(i));
      end
   end

   // The pointer only moves when a packet completes, so a locked VC keeps its turn.
   assign ptr_adv = grant && vc_tail[gnt_id];
`else
   logic unused_tail;
   assign unused_tail = ^vc_tail;
   assign lock_mask   = '1;
   assign ptr_adv     = grant;
`endif

   always_comb begin
      req = '0;
      for (int i = 0; i < VC_NUM; i++)
         req[i] = vc_valid[i] && (cnt[i] != '0) && lock_mask[i];
   end

   // Reverse scan so the VC closest to ptr is the last (and final) assignment.
   always_comb begin
      any_req = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      for (int k = VC_NUM - 1; k >= 0; k--) begin
         idx = wrap_add(ptr, k);
         if (req[idx]) begin
            any_req = 1'b1;
            gnt_id  = idx;
         end
      end
   end

   assign grant = any_req && out_ready && reset;

   always_comb begin
      vc_pop   = '0;
      gnt_flit = '0;
      for (int i = 0; i < VC_NUM; i++) begin
         vc_pop[i] = grant && (gnt_id == VC_ID_W'(i));
         if (gnt_id == VC_ID_W'(i)) gnt_flit = flit_in[i*FLIT_SIZE +: FLIT_SIZE];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
         for (int i = 0; i < VC_NUM; i++) cnt[i] <= CNT_W'(CREDIT_DEPTH);
      end else begin
         if (ptr_adv) ptr <= wrap_add(gnt_id, 1);
         for (int i = 0; i < VC_NUM; i++)
            cnt[i] <= credit_next(cnt[i], vc_pop[i], credit_return[i]);
      end
   end

   // Stage p0 -> output register: granted flit appears one cycle after its pop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         flit_valid <= 1'b0;
         flit_out   <= '0;
         grant_vc   <= '0;
      end else begin
         flit_valid <= grant;
         if (grant) begin
            flit_out <= gnt_flit;
            grant_vc <= gnt_id;
         end
      end
   end

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Bench for vc_output_arbiter: vector table, directed corner sequences and random traffic vs a reference model.
module tb_vc_output_arbiter;
   localparam int VN = 4, IDW = 2, DEPTH = 4, CW = 3, FS = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic [FS*VN-1:0]  flit_in;
   logic [0:VN-1]     vc_valid, vc_tail, credit_return, vc_pop;
   logic              out_ready, flit_valid;
   logic [FS-1:0]     flit_out;
   logic [IDW-1:0]    grant_vc;

   int checks = 0, failures = 0;

   // Reference model state
   int          m_cnt [VN];
   int          m_ptr, m_lock, m_gvc;
   bit          m_hold, m_fv;
   logic [FS-1:0] m_fo;
   int          last_grant;
   logic [0:VN-1] pop_seen;

   vc_output_arbiter #(.VC_NUM(VN), .VC_ID_W(IDW), .CREDIT_DEPTH(DEPTH), .CNT_W(CW), .FLIT_SIZE(FS)) dut (
      .clock(clock), .reset(reset), .flit_in(flit_in), .vc_valid(vc_valid), .vc_tail(vc_tail),
      .credit_return(credit_return), .out_ready(out_ready), .vc_pop(vc_pop), .flit_out(flit_out),
      .flit_valid(flit_valid), .grant_vc(grant_vc));

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < VN; i++) m_cnt[i] = DEPTH;
      m_ptr = 0; m_lock = 0; m_hold = 0; m_fv = 0; m_fo = '0; m_gvc = 0;
   endtask

   function automatic int model_pick();
      int v;
      if (!reset || !out_ready) return -1;
      for (int k = 0; k < VN; k++) begin
         v = (m_ptr + k) % VN;
         if (vc_valid[v] && m_cnt[v] > 0 && (!m_hold || v == m_lock)) return v;
      end
      return -1;
   endfunction

   task automatic model_commit(input int g);
      if (g >= 0) begin
         m_fv = 1; m_fo = flit_in[g*FS +: FS]; m_gvc = g; m_cnt[g]--;
`ifdef VC_ARB_PKT_LOCK_EN
         if (!vc_tail[g]) begin m_hold = 1; m_lock = g; end
         else begin m_hold = 0; m_ptr = (g + 1) % VN; end
`else
         m_ptr = (g + 1) % VN;
`endif
      end else begin
         m_fv = 0;
      end
      for (int i = 0; i < VN; i++)
         if (credit_return[i] && m_cnt[i] < DEPTH) m_cnt[i]++;
   endtask

   // One clock: check combinational pop, advance, check registered outputs.
   task automatic step();
      int g;
      logic [0:VN-1] ep;
      #2;
      g = model_pick();
      ep = '0;
      if (g >= 0) ep[g] = 1'b1;
      pop_seen = vc_pop;
      check("vc_pop", int'(vc_pop), int'(ep));
      last_grant = g;
      @(posedge clock);
      if (!reset) model_reset(); else model_commit(g);
      #1;
      check("flit_valid", int'(flit_valid), int'(m_fv));
      check("flit_out", int'(flit_out), int'(m_fo));
      check("grant_vc", int'(grant_vc), m_gvc);
   endtask

   task automatic set_in(input logic [0:VN-1] v, input logic [0:VN-1] t,
                         input logic [0:VN-1] r, input logic rdy);
      vc_valid = v; vc_tail = t; credit_return = r; out_ready = rdy;
      flit_in = {$urandom, $urandom};
   endtask

   task automatic do_reset();
      reset = 1'b0;
      set_in('0, '0, '0, 1'b0);
      step();
      step();
      reset = 1'b1;
   endtask

   typedef struct {
      logic [0:VN-1] valid;
      logic          ready;
      logic [0:VN-1] exp_pop;
      logic          exp_fv;
      logic [IDW-1:0] exp_gvc;
   } vec_t;

   vec_t tbl [14];
   int   n_pop, cnt_v;
   int   gcount [VN];
   int   exp_seq [4];

   initial begin
      // Round-robin over all VCs, then backpressure with VC0/VC3 and release.
      tbl[0]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd0};
      tbl[1]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
      tbl[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd2};
      tbl[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
      tbl[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd0};
      tbl[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
      tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd2};
      tbl[7]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
      tbl[8]  = '{4'b1001, 1'b0, 4'b0000, 1'b0, 2'd3};
      tbl[9]  = '{4'b1001, 1'b0, 4'b0000, 1'b0, 2'd3};
      tbl[10] = '{4'b1001, 1'b0, 4'b0000, 1'b0, 2'd3};
      tbl[11] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd0};
      tbl[12] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3};
      tbl[13] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd0};

      model_reset();
      last_grant = -1;
      do_reset();

      for (int r = 0; r < 14; r++) begin
         set_in(tbl[r].valid, 4'b1111, '0, tbl[r].ready);
         step();
         check("tbl_pop", int'(pop_seen), int'(tbl[r].exp_pop));
         check("tbl_valid", int'(flit_valid), int'(tbl[r].exp_fv));
         check("tbl_gvc", int'(grant_vc), int'(tbl[r].exp_gvc));
         if (tbl[r].exp_fv)
            check("tbl_flit", int'(flit_out), int'(flit_in[int'(tbl[r].exp_gvc)*FS +: FS]));
      end

      // Credit exhaustion on VC2, then a single return buys one more grant.
      do_reset();
      n_pop = 0;
      for (int c = 0; c < 6; c++) begin
         set_in(4'b0010, 4'b1111, '0, 1'b1); step();
         if (last_grant == 2) n_pop++;
      end
      check("exhaust_grants", n_pop, 4);
      n_pop = 0;
      set_in(4'b0010, 4'b1111, 4'b0010, 1'b1); step();
      if (last_grant == 2) n_pop++;
      for (int c = 0; c < 4; c++) begin
         set_in(4'b0010, 4'b1111, '0, 1'b1); step();
         if (last_grant == 2) n_pop++;
      end
      check("return_grants", n_pop, 1);

      // Grant and return together on VC1 at cnt=1 leave cnt at 1.
      do_reset();
      n_pop = 0;
      for (int c = 0; c < 3; c++) begin
         set_in(4'b0100, 4'b1111, '0, 1'b1); step();
         if (last_grant == 1) n_pop++;
      end
      set_in(4'b0100, 4'b1111, 4'b0100, 1'b1); step();
      if (last_grant == 1) n_pop++;
      for (int c = 0; c < 3; c++) begin
         set_in(4'b0100, 4'b1111, '0, 1'b1); step();
         if (last_grant == 1) n_pop++;
      end
      check("simul_grants", n_pop, 5);

      // A return at full credit is ignored.
      do_reset();
      set_in('0, 4'b1111, 4'b0100, 1'b1); step();
      n_pop = 0;
      for (int c = 0; c < 6; c++) begin
         set_in(4'b0100, 4'b1111, '0, 1'b1); step();
         if (last_grant == 1) n_pop++;
      end
      check("sat_grants", n_pop, 4);

      // Packet on VC0 (tail on third flit) against a continuously valid VC1.
      do_reset();
`ifdef VC_ARB_PKT_LOCK_EN
      exp_seq = '{0, 0, 0, 1};
`else
      exp_seq = '{0, 1, 0, 1};
`endif
      for (int c = 0; c < 4; c++) begin
         if (c < 2)      set_in(4'b1100, 4'b0100, '0, 1'b1);
         else if (c == 2) set_in(4'b1100, 4'b1100, '0, 1'b1);
         else            set_in(4'b0100, 4'b0100, '0, 1'b1);
         step();
         check("lock_seq", last_grant, exp_seq[c]);
      end

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         set_in(VN'($urandom), VN'($urandom),
                VN'($urandom) & VN'($urandom) & VN'($urandom),
                ($urandom_range(0, 7) != 0));
         step();
      end

      // Asynchronous reset mid-cycle during traffic.
      set_in(4'b1111, 4'b1111, '0, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("rst_flit_valid", int'(flit_valid), 0);
      check("rst_grant_vc", int'(grant_vc), 0);
      check("rst_flit_out", int'(flit_out), 0);
      check("rst_vc_pop", int'(vc_pop), 0);
      @(posedge clock);
      model_reset();
      #1;
      step();
      reset = 1'b1;

      // After reset every VC offers exactly four grants.
      for (int i = 0; i < VN; i++) gcount[i] = 0;
      for (int c = 0; c < 18; c++) begin
         set_in(4'b1111, 4'b1111, '0, 1'b1); step();
         if (last_grant >= 0) gcount[last_grant]++;
      end
      for (int i = 0; i < VN; i++) begin
         cnt_v = gcount[i];
         check("post_rst_grants", cnt_v, 4);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
